// File: rtl/register_file.sv
// register_file: architectural registers with rename tags, commit bypass and flush
module register_file #(
    parameter int REG_WIDTH    = 5,
    parameter int EX_REG_WIDTH = 6,
    parameter int NON_REG      = 32,
    parameter int RoB_WIDTH    = 4,
    parameter int EX_RoB_WIDTH = 5,
    parameter int NON_DEP      = 16
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst_n,
    input  logic                    Sys_rdy,
    input  logic                    RoBRF_pre_judge,
    input  logic                    RoBRF_en,
    input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
    input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
    input  logic [31:0]             RoBRF_value,
    input  logic                    DPRF_en,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
    input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
    output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
    output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
    output logic [31:0]             RFDP_Vj,
    output logic [31:0]             RFDP_Vk
);
    localparam int NREG = 1 << REG_WIDTH;
    localparam logic [EX_RoB_WIDTH-1:0] ND = NON_DEP[EX_RoB_WIDTH-1:0];
    localparam logic [EX_REG_WIDTH-1:0] NR = NON_REG[EX_REG_WIDTH-1:0];

    logic [31:0]             value [NREG];
    logic [EX_RoB_WIDTH-1:0] tag   [NREG];
    logic [EX_RoB_WIDTH-1:0] c_tag;
    logic [EX_RoB_WIDTH-1:0] d_tag;
    logic                    c_wr;
    logic                    d_wr;

    assign c_tag = {1'b0, RoBRF_RoB_index};
    assign d_tag = {1'b0, DPRF_RoB_index};
    assign c_wr  = RoBRF_en && RoBRF_rd != '0 && RoBRF_rd < NR;
    assign d_wr  = DPRF_en && RoBRF_pre_judge && DPRF_rd != '0 && DPRF_rd < NR;

    // returns {Q, V}; a commit whose tag still owns the register bypasses state
    function automatic logic [EX_RoB_WIDTH+31:0] rd_port(input logic [EX_REG_WIDTH-1:0] s);
        logic [EX_RoB_WIDTH-1:0] t;
        t = tag[s[REG_WIDTH-1:0]];
        return (s == '0 || s >= NR) ? {ND, 32'd0} :
               (RoBRF_en && RoBRF_rd == s && t == c_tag) ? {ND, RoBRF_value} :
               {t, (t == ND) ? value[s[REG_WIDTH-1:0]] : 32'd0};
    endfunction

    assign {RFDP_Qj, RFDP_Vj} = rd_port(DPRF_rs1);
    assign {RFDP_Qk, RFDP_Vk} = rd_port(DPRF_rs2);

    // later assignments win: rename over commit clear, flush over everything
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                value[i] <= '0;
                tag[i]   <= ND;
            end
        end else if (Sys_rdy) begin
            if (c_wr) begin
                value[RoBRF_rd[REG_WIDTH-1:0]] <= RoBRF_value;
                if (tag[RoBRF_rd[REG_WIDTH-1:0]] == c_tag)
                    tag[RoBRF_rd[REG_WIDTH-1:0]] <= ND;
            end
            if (d_wr)
                tag[DPRF_rd[REG_WIDTH-1:0]] <= d_tag;
            if (!RoBRF_pre_judge)
                for (int i = 0; i < NREG; i++)
                    tag[i] <= ND;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of rename, commit bypass, flush and reset
module tb_register_file;
    logic        Sys_clk = 0;
    logic        Sys_rst_n;
    logic        Sys_rdy;
    logic        RoBRF_pre_judge;
    logic        RoBRF_en;
    logic [3:0]  RoBRF_RoB_index;
    logic [5:0]  RoBRF_rd;
    logic [31:0] RoBRF_value;
    logic        DPRF_en;
    logic [5:0]  DPRF_rd;
    logic [3:0]  DPRF_RoB_index;
    logic [5:0]  DPRF_rs1;
    logic [5:0]  DPRF_rs2;
    logic [4:0]  RFDP_Qj;
    logic [4:0]  RFDP_Qk;
    logic [31:0] RFDP_Vj;
    logic [31:0] RFDP_Vk;
    int total = 0;
    int bad = 0;

    register_file dut (
        .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy),
        .RoBRF_pre_judge(RoBRF_pre_judge), .RoBRF_en(RoBRF_en),
        .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd), .RoBRF_value(RoBRF_value),
        .DPRF_en(DPRF_en), .DPRF_rd(DPRF_rd), .DPRF_RoB_index(DPRF_RoB_index),
        .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
        .RFDP_Qj(RFDP_Qj), .RFDP_Qk(RFDP_Qk), .RFDP_Vj(RFDP_Vj), .RFDP_Vk(RFDP_Vk)
    );

    always #5 Sys_clk = ~Sys_clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic idle();
        RoBRF_pre_judge = 1;
        RoBRF_en = 0;
        RoBRF_RoB_index = 0;
        RoBRF_rd = 6'd32;
        RoBRF_value = 0;
        DPRF_en = 0;
        DPRF_rd = 6'd32;
        DPRF_RoB_index = 0;
    endtask

    task automatic step();
        @(posedge Sys_clk);
        #1;
        idle();
    endtask

    task automatic commit(input logic [5:0] rd, input logic [3:0] idx, input logic [31:0] v);
        RoBRF_en = 1;
        RoBRF_rd = rd;
        RoBRF_RoB_index = idx;
        RoBRF_value = v;
    endtask

    task automatic dispatch(input logic [5:0] rd, input logic [3:0] idx);
        DPRF_en = 1;
        DPRF_rd = rd;
        DPRF_RoB_index = idx;
    endtask

    task automatic rd1(input string nm, input logic [5:0] s, input logic [4:0] q, input logic [31:0] v);
        DPRF_rs1 = s;
        #1;
        check({nm, "_Qj"}, 32'(RFDP_Qj), 32'(q));
        check({nm, "_Vj"}, RFDP_Vj, v);
    endtask

    initial begin
        idle();
        Sys_rdy = 1;
        Sys_rst_n = 0;
        DPRF_rs1 = 6'd32;
        DPRF_rs2 = 6'd32;
        #12 Sys_rst_n = 1;
        step();
        DPRF_rs2 = 0;
        rd1("rst_x5", 5, 16, 0);
        check("rst_Qk", 32'(RFDP_Qk), 16);
        check("rst_Vk", RFDP_Vk, 0);

        dispatch(3, 7);
        step();
        rd1("ren_x3", 3, 7, 0);
        commit(3, 7, 32'h1234);
        rd1("byp_x3", 3, 16, 32'h1234);
        step();
        rd1("st_x3", 3, 16, 32'h1234);

        dispatch(4, 2);
        step();
        dispatch(4, 9);
        step();
        commit(4, 2, 32'hAA);
        rd1("old_cmt_x4", 4, 9, 0);
        step();
        rd1("young_x4", 4, 9, 0);
        RoBRF_pre_judge = 0;
        step();
        rd1("val_x4", 4, 16, 32'hAA);

        dispatch(6, 5);
        step();
        commit(6, 5, 32'h66);
        dispatch(6, 8);
        rd1("byp_x6", 6, 16, 32'h66);
        step();
        rd1("ovr_x6", 6, 8, 0);
        RoBRF_pre_judge = 0;
        step();
        rd1("val_x6", 6, 16, 32'h66);

        for (int i = 1; i <= 3; i++) begin
            dispatch(6'(i), 4'(i));
            step();
        end
        rd1("ren_x2", 2, 2, 0);
        RoBRF_pre_judge = 0;
        dispatch(10, 4);
        commit(1, 1, 32'h55);
        step();
        rd1("fl_x1", 1, 16, 32'h55);
        rd1("fl_x2", 2, 16, 0);
        rd1("fl_x3", 3, 16, 32'h1234);
        rd1("fl_x10", 10, 16, 0);

        commit(0, 0, 32'hFFFF);
        dispatch(0, 3);
        rd1("x0_same", 0, 16, 0);
        step();
        rd1("x0_next", 0, 16, 0);

        Sys_rdy = 0;
        dispatch(12, 5);
        commit(3, 0, 32'hDEAD);
        step();
        Sys_rdy = 1;
        rd1("rdy0_x12", 12, 16, 0);
        rd1("rdy0_x3", 3, 16, 32'h1234);
        dispatch(12, 5);
        step();
        rd1("rdy1_x12", 12, 5, 0);

        DPRF_rs2 = 3;
        #1;
        check("pre_rst_Vk", RFDP_Vk, 32'h1234);
        Sys_rst_n = 0;
        #2;
        check("arst_Qj", 32'(RFDP_Qj), 16);
        check("arst_Vk", RFDP_Vk, 0);
        step();
        Sys_rst_n = 1;
        rd1("post_rst_x1", 1, 16, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
